store_write_buffer: RTL and testbench

//  FIFO write buffer between the D-cache store path and the unified multi-cycle memory.
//  It queues write-through stores so the CPU does not stall on each memory write.
//  It drains the queued stores into memory whenever the miss/fill FSM is idle.
//  It flags a read-miss fill whose block matches a pending store, so the fill never returns stale data.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/wb_fifo_ram.sv | 40 ++++
 rtl/store_write_buffer.sv | 123 ++++++++++++
 tb/tb_store_write_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-subsystem constants used by the cache, the fill FSM and the store write buffer.
package mem_pkg;

  // Address and data widths of the unified memory port
  localparam int unsigned MEM_AW      = 16;
  localparam int unsigned MEM_DW      = 16;

  // Low address bit of the cache-block tag: 8 words x 2 bytes per block
  localparam int unsigned MEM_BLK_LSB = 4;

  // Store write buffer depth (power of two, at least 2)
  localparam int unsigned WB_DEPTH    = 4;

  // Memory opcodes seen on the CPU store/load path
  typedef enum logic [3:0] {
    OP_LW = 4'b1000,
    OP_SW = 4'b1001
  } mem_op_e;

  // Returns the cache-block tag of a full-width address
  function automatic logic [MEM_AW-MEM_BLK_LSB-1:0] blk_tag(input logic [MEM_AW-1:0] addr);
    return addr[MEM_AW-1:MEM_BLK_LSB];
  endfunction

endpackage

// File: rtl/wb_fifo_ram.sv
// Register array backing the store write buffer: one write port, one asynchronous read port,
// plus a tap of every entry's block tag for the fill-conflict comparator.
module wb_fifo_ram
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned W     = MEM_AW + MEM_DW,
  parameter int unsigned TW    = MEM_AW - MEM_BLK_LSB,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [PW-1:0]             waddr,
  input  logic [W-1:0]              wdata,
  input  logic [PW-1:0]             raddr,
  output logic [W-1:0]              rdata,
  output logic [DEPTH-1:0][TW-1:0]  tags
);

  logic [W-1:0] mem_q [DEPTH];

  // Entry write; contents need no reset since validity is tracked by the owner
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous head read
  assign rdata = mem_q[raddr];

  // Expose the tag field (top TW bits of each entry) for block matching
  always_comb begin
    tags = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      tags[i] = mem_q[i][W-1 -: TW];
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// FIFO write buffer between the D-cache store path and the multi-cycle memory.
// Queues write-through stores, drains them while the fill FSM is idle, and flags
// any fill whose block still has a pending store so the fill never reads stale data.
module store_write_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = WB_DEPTH,
  parameter int unsigned AW      = MEM_AW,
  parameter int unsigned DW      = MEM_DW,
  parameter int unsigned BLK_LSB = MEM_BLK_LSB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     fill_req,
  input  logic [AW-1:0]            fill_addr,
  output logic                     fill_conflict,
  input  logic                     mem_idle,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned EW  = AW + DW;
  localparam int unsigned TW  = AW - BLK_LSB;

  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [DEPTH-1:0]          valid_q;
  logic [EW-1:0]             head;
  logic [DEPTH-1:0][TW-1:0]  tags;
  logic [DEPTH-1:0]          hit;
  logic [CW1-1:0]            cnt_sum;
  logic                      full;
  logic                      push;
  logic                      drain;
  logic                      unused_fill_lo;

  // Entry storage: written at wr_ptr on push, head read at rd_ptr
  wb_fifo_ram #(
    .DEPTH (DEPTH),
    .W     (EW),
    .TW    (TW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({st_addr, st_data}),
    .raddr (rd_ptr),
    .rdata (head),
    .tags  (tags)
  );

  // Occupancy flags and handshake; a full buffer stalls the CPU store
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign st_ready = !full;
  assign push     = st_valid && !full;

  // Block-level match of the fill address against every valid pending store
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit[i] = valid_q[i] && (tags[i] == fill_addr[AW-1:BLK_LSB]);
    end
  end

  assign fill_conflict  = fill_req && (|hit);
  assign unused_fill_lo = ^fill_addr[BLK_LSB-1:0];

  // Drain whenever memory is free, and ahead of any fill that is blocked by a pending store
  assign drain = !empty && mem_idle && (!fill_req || fill_conflict);

  // Next occupancy, one bit wider so that overflow or underflow is observable
  assign cnt_sum = CW1'(count) + CW1'(push) - CW1'(drain);

  // Pointers, per-entry validity, occupancy and registered memory-write outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      valid_q  <= '0;
      count    <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + PW'(1);
        valid_q[wr_ptr] <= 1'b1;
      end
      if (drain) begin
        rd_ptr          <= rd_ptr + PW'(1);
        valid_q[rd_ptr] <= 1'b0;
        mem_addr        <= head[EW-1:DW];
        mem_data        <= head[DW-1:0];
      end
      mem_en <= drain;
      count  <= cnt_sum[CW-1:0];
    end
  end

  // Write strobe always accompanies the enable for a drain
  assign mem_wr = mem_en;

  // Occupancy must stay within 0..DEPTH
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt_sum <= CW1'(DEPTH))
        else $error("store_write_buffer: occupancy out of range (%0d)", cnt_sum);
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with a queue-based scoreboard on the drain port.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        st_ready;
  logic        fill_req;
  logic [15:0] fill_addr;
  logic        fill_conflict;
  logic        mem_idle;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        empty;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  store_write_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_ready      (st_ready),
    .fill_req      (fill_req),
    .fill_addr     (fill_addr),
    .fill_conflict (fill_conflict),
    .mem_idle      (mem_idle),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .empty         (empty),
    .count         (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Present a store; if it is expected to reach memory, record it for the scoreboard
  task automatic put(input logic [15:0] a, input logic [15:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    exp_q.push_back({a, d});
  endtask

  // Scoreboard monitor: every memory write must be the next expected store, in order
  always @(posedge clk) begin
    #1;
    if (mem_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain_unexpected: got addr %h data %h, required no drain", mem_addr, mem_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("drain_word", {mem_addr, mem_data}, e);
        chk("drain_wr", 32'(mem_wr), 32'd1);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    fill_req = 1'b0; fill_addr = '0; mem_idle = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_conflict", 32'(fill_conflict), 32'd0);
    rst = 1'b0;

    // 1: three stores drained one cycle after each push
    mem_idle = 1'b1;
    put(16'h0010, 16'hAAAA);
    @(negedge clk); chk("t1_en_first", 32'(mem_en), 32'd0); put(16'h0012, 16'hBBBB);
    @(negedge clk); chk("t1_en_a", 32'(mem_en), 32'd1); put(16'h0020, 16'hCCCC);
    @(negedge clk); chk("t1_en_b", 32'(mem_en), 32'd1); st_valid = 1'b0;
    @(negedge clk); chk("t1_en_c", 32'(mem_en), 32'd1);
    chk("t1_empty", 32'(empty), 32'd1); chk("t1_count", 32'(count), 32'd0);
    @(negedge clk); chk("t1_en_off", 32'(mem_en), 32'd0);

    // 2: fill to DEPTH, held fifth store, then drain in order
    mem_idle = 1'b0;
    put(16'h0100, 16'h1000); @(negedge clk);
    put(16'h0102, 16'h1001); @(negedge clk);
    put(16'h0104, 16'h1002); @(negedge clk);
    put(16'h0106, 16'h1003); @(negedge clk);
    chk("t2_count_full", 32'(count), 32'd4); chk("t2_ready_full", 32'(st_ready), 32'd0);
    put(16'h0200, 16'h2000);
    @(negedge clk);
    chk("t2_count_hold", 32'(count), 32'd4); chk("t2_ready_hold", 32'(st_ready), 32'd0);
    chk("t2_no_drain", 32'(mem_en), 32'd0);
    mem_idle = 1'b1;
    @(negedge clk);
    chk("t2_en", 32'(mem_en), 32'd1); chk("t2_count_pop", 32'(count), 32'd3);
    chk("t2_ready_back", 32'(st_ready), 32'd1);
    @(negedge clk);
    chk("t2_count_pushpop", 32'(count), 32'd3); st_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: conflicting fill forces the matching store out first
    mem_idle = 1'b0;
    put(16'h0034, 16'h3434);
    @(negedge clk);
    st_valid = 1'b0; chk("t3_count", 32'(count), 32'd1);
    fill_req = 1'b1; fill_addr = 16'h003E; mem_idle = 1'b1;
    #1 chk("t3_conflict", 32'(fill_conflict), 32'd1);
    @(negedge clk);
    chk("t3_en", 32'(mem_en), 32'd1); chk("t3_conflict_clr", 32'(fill_conflict), 32'd0);
    chk("t3_count_pop", 32'(count), 32'd0);
    fill_req = 1'b0;

    // 4: non-conflicting fill blocks draining until it drops
    mem_idle = 1'b0;
    put(16'h0034, 16'h4444);
    @(negedge clk);
    st_valid = 1'b0; fill_addr = 16'h0030;
    #1 chk("t4_noreq_conflict", 32'(fill_conflict), 32'd0);
    fill_req = 1'b1; fill_addr = 16'h0040; mem_idle = 1'b1;
    #1 chk("t4_conflict", 32'(fill_conflict), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_blocked_en", 32'(mem_en), 32'd0); chk("t4_blocked_count", 32'(count), 32'd1);
    end
    fill_req = 1'b0;
    @(negedge clk);
    chk("t4_en", 32'(mem_en), 32'd1); chk("t4_count", 32'(count), 32'd0);

    // 5: full buffer streamed through with pointer wrap over 2*DEPTH stores
    mem_idle = 1'b0;
    for (int k = 0; k < 4; k++) begin
      put(16'h0400 + 16'(2 * k), 16'h5000 + 16'(k));
      @(negedge clk);
    end
    chk("t5_count_full", 32'(count), 32'd4);
    mem_idle = 1'b1;
    put(16'h0408, 16'h5004);
    @(negedge clk);
    chk("t5_count_first", 32'(count), 32'd3); chk("t5_ready", 32'(st_ready), 32'd1);
    chk("t5_en", 32'(mem_en), 32'd1);
    for (int k = 5; k < 8; k++) begin
      @(negedge clk);
      chk("t5_count_steady", 32'(count), 32'd3);
      put(16'h0400 + 16'(2 * k), 16'h5000 + 16'(k));
    end
    @(negedge clk);
    chk("t5_count_last", 32'(count), 32'd3); st_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_empty", 32'(empty), 32'd1);

    // 6: reset while a drain is in flight discards pending stores
    mem_idle = 1'b0;
    put(16'h0600, 16'h6000); @(negedge clk);
    put(16'h0602, 16'h6001); @(negedge clk);
    put(16'h0604, 16'h6002); @(negedge clk);
    st_valid = 1'b0; mem_idle = 1'b1;
    @(negedge clk);
    chk("t6_en_pre", 32'(mem_en), 32'd1); chk("t6_count_pre", 32'(count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_en", 32'(mem_en), 32'd0); chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1); chk("t6_ready", 32'(st_ready), 32'd1);
    exp_q.delete();
    rst = 1'b0;
    put(16'h0700, 16'h7000);
    @(negedge clk);
    st_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
